// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-enabled data memory.
// Holds the controller state encoding and the default geometry.
// Geometry: 512 words of 32 bits, 9-bit word address.
package dmem_pkg;

   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_ADDR_W = 9;
   localparam int DMEM_DEPTH  = 512;

   // CLEAR walks the whole array writing zeros; READY serves accesses.
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

endpackage

// File: rtl/dmem_byte_merge.sv
// Per-byte merge of an old word with new data under a byte-enable mask.
// Latency: purely combinational, no state.
// Ports: i_old (current word), i_new (write data), i_be (byte enables), o_merged (result).
module dmem_byte_merge
   import dmem_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic [DATA_W-1:0]   i_old,
   input  logic [DATA_W-1:0]   i_new,
   input  logic [DATA_W/8-1:0] i_be,
   output logic [DATA_W-1:0]   o_merged
);

   always_comb begin
      o_merged = i_old;
      for (int i = 0; i < DATA_W/8; i++) begin
         if (i_be[i]) begin
            o_merged[8*i +: 8] = i_new[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_sync.sv
// Synchronous data memory: 1R/1W, byte-enabled writes, self-clearing after reset.
// Latency: read data and readValid one cycle after MemRead; addrErr one cycle after the bad access.
// Backpressure: none; while busy (clearing) all requests are dropped silently.
// Ports: clk/reset (sync, active-high); MemRead/readAddress; MemWrite/writeAddress/writeData/byteEn;
//        readData/readValid (registered read result), busy (clear in progress), addrErr (out-of-range pulse).
module dmem_sync
   import dmem_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W,
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DEPTH  = DMEM_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                MemRead,
   input  logic [ADDR_W-1:0]   readAddress,
   input  logic                MemWrite,
   input  logic [ADDR_W-1:0]   writeAddress,
   input  logic [DATA_W-1:0]   writeData,
   input  logic [DATA_W/8-1:0] byteEn,
   output logic [DATA_W-1:0]   readData,
   output logic                readValid,
   output logic                busy,
   output logic                addrErr
);

   // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_cnt;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_read_data;
   logic                r_read_valid;
   logic                r_addr_err;

   logic                w_rd_in_range;
   logic                w_wr_in_range;
   logic [ADDR_W-1:0]   w_rd_idx;
   logic [ADDR_W-1:0]   w_wr_idx;
   logic [DATA_W-1:0]   w_wr_old;
   logic [DATA_W-1:0]   w_merged;
   logic [DATA_W-1:0]   w_rd_word;
   logic                w_clearing;
   logic                w_rd_fire;
   logic                w_wr_fire;
   logic                w_err;
   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_idx;
   logic [DATA_W-1:0]   w_mem_wdata;

   assign w_rd_in_range = ({1'b0, readAddress}  < LP_DEPTH);
   assign w_wr_in_range = ({1'b0, writeAddress} < LP_DEPTH);

   // Out-of-range addresses are steered to word 0 so the array is never
   // indexed past its end; the enables below keep those accesses inert.
   assign w_rd_idx = w_rd_in_range ? readAddress  : '0;
   assign w_wr_idx = w_wr_in_range ? writeAddress : '0;

   assign w_wr_old = r_mem[w_wr_idx];

   // Single merge serves both the array write and same-address read forwarding.
   dmem_byte_merge #(
      .DATA_W (DATA_W)
   ) u_merge (
      .i_old    (w_wr_old),
      .i_new    (writeData),
      .i_be     (byteEn),
      .o_merged (w_merged)
   );

   // Write-first: a read hitting the word being written sees the merged word.
   assign w_rd_word = !w_rd_in_range ? '0 :
                      (w_wr_fire && (writeAddress == readAddress)) ? w_merged :
                      r_mem[w_rd_idx];

   // ---- FSM: state register ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---- FSM: next state ----
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CLEAR: if (r_cnt == LP_LAST) w_state_nxt = READY;
         READY: w_state_nxt = READY;
      endcase
   end

   // ---- FSM: outputs / datapath controls ----
   always_comb begin
      w_clearing  = 1'b0;
      w_rd_fire   = 1'b0;
      w_wr_fire   = 1'b0;
      w_err       = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_idx   = w_wr_idx;
      w_mem_wdata = w_merged;
      case (r_state)
         CLEAR: begin
            w_clearing  = 1'b1;
            w_mem_we    = ~reset;
            w_mem_idx   = r_cnt;
            w_mem_wdata = '0;
         end
         READY: begin
            w_rd_fire = MemRead;
            w_wr_fire = MemWrite & w_wr_in_range;
            // Gate with reset so an access coinciding with reset leaves memory alone.
            w_mem_we  = w_wr_fire & ~reset;
            w_err     = (MemRead & ~w_rd_in_range) | (MemWrite & ~w_wr_in_range);
         end
      endcase
   end

   // Clear counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt        <= '0;
         r_read_data  <= '0;
         r_read_valid <= 1'b0;
         r_addr_err   <= 1'b0;
      end else begin
         r_cnt        <= w_clearing ? r_cnt + ADDR_W'(1) : '0;
         r_read_valid <= w_rd_fire;
         r_addr_err   <= w_err;
         if (w_rd_fire) begin
            r_read_data <= w_rd_word;
         end
      end
   end

   // Storage: one write port shared by the clear walk and user writes.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_idx] <= w_mem_wdata;
      end
   end

   assign readData  = r_read_data;
   assign readValid = r_read_valid;
   assign addrErr   = r_addr_err;
   assign busy      = (r_state == CLEAR);

endmodule

// File: tb/tb_dmem_sync.sv
// Self-checking bench for dmem_sync: default geometry plus a DEPTH=300 instance.
module tb_dmem_sync;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        MemRead, MemWrite;
   logic [8:0]  readAddress, writeAddress;
   logic [31:0] writeData;
   logic [3:0]  byteEn;
   logic [31:0] readData;
   logic        readValid, busy, addrErr;

   logic        d2_MemRead, d2_MemWrite;
   logic [8:0]  d2_readAddress, d2_writeAddress;
   logic [31:0] d2_writeData;
   logic [3:0]  d2_byteEn;
   logic [31:0] d2_readData;
   logic        d2_readValid, d2_busy, d2_addrErr;

   dmem_sync u_dut (
      .clk          (clk),
      .reset        (reset),
      .MemRead      (MemRead),
      .readAddress  (readAddress),
      .MemWrite     (MemWrite),
      .writeAddress (writeAddress),
      .writeData    (writeData),
      .byteEn       (byteEn),
      .readData     (readData),
      .readValid    (readValid),
      .busy         (busy),
      .addrErr      (addrErr)
   );

   dmem_sync #(.DATA_W(32), .ADDR_W(9), .DEPTH(300)) u_dut300 (
      .clk          (clk),
      .reset        (reset),
      .MemRead      (d2_MemRead),
      .readAddress  (d2_readAddress),
      .MemWrite     (d2_MemWrite),
      .writeAddress (d2_writeAddress),
      .writeData    (d2_writeData),
      .byteEn       (d2_byteEn),
      .readData     (d2_readData),
      .readValid    (d2_readValid),
      .busy         (d2_busy),
      .addrErr      (d2_addrErr)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain word array, updated byte-by-byte, write-first reads.
   logic [31:0] m_mem [512];
   logic [31:0] m_rdata;
   logic        m_valid;
   logic        m_ready;

   typedef struct packed {
      logic        mr;
      logic [8:0]  ra;
      logic        mw;
      logic [8:0]  wa;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        ev;
      logic [31:0] ed;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic step(input logic mr, input logic [8:0] ra, input logic mw,
                       input logic [8:0] wa, input logic [31:0] wd, input logic [3:0] be);
      MemRead      = mr;
      readAddress  = ra;
      MemWrite     = mw;
      writeAddress = wa;
      writeData    = wd;
      byteEn       = be;
      if (m_ready) begin
         if (mw) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) m_mem[wa][8*i +: 8] = wd[8*i +: 8];
            end
         end
         m_valid = mr;
         if (mr) m_rdata = m_mem[ra];
      end
      @(negedge clk);
   endtask

   task automatic step2(input logic mr, input logic [8:0] ra, input logic mw,
                        input logic [8:0] wa, input logic [31:0] wd, input logic [3:0] be);
      d2_MemRead      = mr;
      d2_readAddress  = ra;
      d2_MemWrite     = mw;
      d2_writeAddress = wa;
      d2_writeData    = wd;
      d2_byteEn       = be;
      @(negedge clk);
   endtask

   task automatic idle_main();
      MemRead = 1'b0; readAddress = '0; MemWrite = 1'b0;
      writeAddress = '0; writeData = '0; byteEn = '0;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " readValid"}, 32'(readValid), 32'(m_valid));
      chk({tag, " readData"},  readData, m_rdata);
      chk({tag, " addrErr"},   32'(addrErr), 32'd0);
      chk({tag, " busy"},      32'(busy), 32'd0);
   endtask

   // Applies reset for one edge with whatever access the caller left on the
   // inputs, checks the reset values, then optionally counts the busy window.
   task automatic do_reset(input bit count_it, input bit poke_clear, output int nb, output int nb2);
      int bad;
      reset = 1'b1;
      @(negedge clk);
      chk("reset readData",  readData, 32'd0);
      chk("reset readValid", 32'(readValid), 32'd0);
      chk("reset addrErr",   32'(addrErr), 32'd0);
      chk("reset busy",      32'(busy), 32'd1);
      reset   = 1'b0;
      m_ready = 1'b0;
      for (int i = 0; i < 512; i++) m_mem[i] = '0;
      m_rdata = '0;
      m_valid = 1'b0;
      if (poke_clear) begin
         MemRead = 1'b1; readAddress = 9'h005; MemWrite = 1'b1;
         writeAddress = 9'h005; writeData = 32'hCAFEF00D; byteEn = 4'hF;
      end else begin
         idle_main();
      end
      nb = 0; nb2 = 0; bad = 0;
      if (count_it) begin
         while ((busy || d2_busy) && nb < 2000) begin
            if (busy) nb++;
            if (d2_busy) nb2++;
            if (readValid || addrErr) bad++;
            @(negedge clk);
         end
         idle_main();
         chk("accesses dropped while clearing", 32'(bad), 32'd0);
         m_ready = 1'b1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, nb2;
      logic        rmr, rmw;
      logic [8:0]  rra, rwa;
      logic [31:0] rwd;
      logic [3:0]  rbe;

      reset = 1'b1;
      m_ready = 1'b0;
      m_rdata = '0;
      m_valid = 1'b0;
      idle_main();
      d2_MemRead = 1'b0; d2_readAddress = '0; d2_MemWrite = 1'b0;
      d2_writeAddress = '0; d2_writeData = '0; d2_byteEn = '0;

      // Initial clear, with a write/read hammering word 5 the whole time.
      do_reset(1'b1, 1'b1, nb, nb2);
      chk("busy cycles DEPTH=512", 32'(nb), 32'd512);
      chk("busy cycles DEPTH=300", 32'(nb2), 32'd300);

      step(1'b1, 9'h005, 1'b0, 9'h000, 32'h0, 4'h0);
      chk("clear-time write ignored", readData, 32'h0);
      chk("read @005 valid", 32'(readValid), 32'd1);
      step(1'b1, 9'h1FF, 1'b0, 9'h000, 32'h0, 4'h0);
      chk("read last word data", readData, 32'h0);
      chk("read last word valid", 32'(readValid), 32'd1);
      chk("read last word addrErr", 32'(addrErr), 32'd0);

      // mr, ra, mw, wa, wd, be, expected valid, expected data
      tbl[0] = '{1'b0, 9'h000, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000};
      tbl[1] = '{1'b0, 9'h000, 1'b1, 9'h010, 32'h0000AA00, 4'h2, 1'b0, 32'h00000000};
      tbl[2] = '{1'b1, 9'h010, 1'b0, 9'h000, 32'h00000000, 4'h0, 1'b1, 32'hDEADAAEF};
      tbl[3] = '{1'b1, 9'h020, 1'b1, 9'h020, 32'h12345678, 4'hF, 1'b1, 32'h12345678};
      tbl[4] = '{1'b0, 9'h020, 1'b0, 9'h000, 32'h00000000, 4'h0, 1'b0, 32'h12345678};
      tbl[5] = '{1'b1, 9'h030, 1'b1, 9'h030, 32'hAABBCCDD, 4'h0, 1'b1, 32'h00000000};
      tbl[6] = '{1'b1, 9'h010, 1'b1, 9'h040, 32'h11223344, 4'h5, 1'b1, 32'hDEADAAEF};
      tbl[7] = '{1'b1, 9'h040, 1'b0, 9'h000, 32'h00000000, 4'h0, 1'b1, 32'h00220044};
      tbl[8] = '{1'b1, 9'h040, 1'b1, 9'h040, 32'hFFFFFFFF, 4'h8, 1'b1, 32'hFF220044};
      tbl[9] = '{1'b0, 9'h000, 1'b0, 9'h000, 32'h00000000, 4'h0, 1'b0, 32'hFF220044};

      for (int v = 0; v < 10; v++) begin
         step(tbl[v].mr, tbl[v].ra, tbl[v].mw, tbl[v].wa, tbl[v].wd, tbl[v].be);
         chk($sformatf("vec%0d readValid", v), 32'(readValid), 32'(tbl[v].ev));
         chk($sformatf("vec%0d readData", v),  readData, tbl[v].ed);
         chk($sformatf("vec%0d addrErr", v),   32'(addrErr), 32'd0);
      end

      // Random traffic, mostly on a handful of words so reads and writes collide.
      for (int n = 0; n < 400; n++) begin
         rmr = 1'($urandom_range(0, 1));
         rmw = 1'($urandom_range(0, 1));
         rra = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
         rwa = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
         rwd = $urandom;
         rbe = 4'($urandom_range(0, 15));
         step(rmr, rra, rmw, rwa, rwd, rbe);
         check_model($sformatf("rand%0d", n));
      end
      idle_main();

      // DEPTH=300 instance: last valid word and first invalid word.
      step2(1'b0, 9'h000, 1'b1, 9'h12B, 32'hAABBCCDD, 4'hF);
      chk("d300 write @12B addrErr", 32'(d2_addrErr), 32'd0);
      step2(1'b1, 9'h12B, 1'b0, 9'h000, 32'h0, 4'h0);
      chk("d300 read @12B data", d2_readData, 32'hAABBCCDD);
      chk("d300 read @12B valid", 32'(d2_readValid), 32'd1);
      chk("d300 read @12B addrErr", 32'(d2_addrErr), 32'd0);
      step2(1'b0, 9'h000, 1'b1, 9'h12C, 32'h11111111, 4'hF);
      chk("d300 write @12C addrErr", 32'(d2_addrErr), 32'd1);
      chk("d300 write @12C valid", 32'(d2_readValid), 32'd0);
      step2(1'b0, 9'h000, 1'b0, 9'h000, 32'h0, 4'h0);
      chk("d300 addrErr single pulse", 32'(d2_addrErr), 32'd0);
      chk("d300 readData held", d2_readData, 32'hAABBCCDD);
      step2(1'b1, 9'h12C, 1'b0, 9'h000, 32'h0, 4'h0);
      chk("d300 read @12C data", d2_readData, 32'h0);
      chk("d300 read @12C valid", 32'(d2_readValid), 32'd1);
      chk("d300 read @12C addrErr", 32'(d2_addrErr), 32'd1);
      step2(1'b1, 9'h12B, 1'b0, 9'h000, 32'h0, 4'h0);
      chk("d300 @12B unchanged", d2_readData, 32'hAABBCCDD);
      step2(1'b1, 9'h000, 1'b0, 9'h000, 32'h0, 4'h0);
      chk("d300 @000 unchanged", d2_readData, 32'h0);
      step2(1'b1, 9'h1FF, 1'b1, 9'h1FF, 32'h22222222, 4'hF);
      chk("d300 rw @1FF addrErr", 32'(d2_addrErr), 32'd1);
      chk("d300 rw @1FF data", d2_readData, 32'h0);
      step2(1'b0, 9'h000, 1'b0, 9'h000, 32'h0, 4'h0);

      // Reset mid-access, then reset again partway through the clear.
      step(1'b0, 9'h000, 1'b1, 9'h007, 32'h5A5AA5A5, 4'hF);
      step(1'b1, 9'h007, 1'b0, 9'h000, 32'h0, 4'h0);
      chk("pre-reset read @007", readData, 32'h5A5AA5A5);
      MemRead = 1'b1; readAddress = 9'h007; MemWrite = 1'b1;
      writeAddress = 9'h007; writeData = 32'hFFFFFFFF; byteEn = 4'hF;
      do_reset(1'b0, 1'b0, nb, nb2);
      repeat (100) @(negedge clk);
      chk("busy at clear count 100", 32'(busy), 32'd1);
      do_reset(1'b1, 1'b0, nb, nb2);
      chk("busy cycles after mid-clear reset", 32'(nb), 32'd512);
      chk("busy cycles DEPTH=300 after reset", 32'(nb2), 32'd300);
      step(1'b1, 9'h007, 1'b0, 9'h000, 32'h0, 4'h0);
      chk("read @007 after re-clear", readData, 32'h0);
      chk("read @007 after re-clear valid", 32'(readValid), 32'd1);
      step(1'b1, 9'h010, 1'b0, 9'h000, 32'h0, 4'h0);
      chk("read @010 after re-clear", readData, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_sync.md
DMEM_SYNC -- requirements
Module: dmem_sync

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 9, word address width.
REQ-003 Parameter DEPTH, default 512, number of words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 MemRead  input  1  read request, sampled each cycle.
REQ-007 readAddress  input  ADDR_W  word read address.
REQ-008 MemWrite  input  1  write request, sampled each cycle.
REQ-009 writeAddress  input  ADDR_W  word write address.
REQ-010 writeData  input  DATA_W  write data.
REQ-011 byteEn  input  DATA_W/8  per-byte write enable; bit i covers writeData[8i+7:8i].
REQ-012 readData  output  DATA_W  registered read data.
REQ-013 readValid  output  1  one-cycle pulse, readData valid.
REQ-014 busy  output  1  high while clearing; requests ignored.
REQ-015 addrErr  output  1  one-cycle pulse, out-of-range access in previous cycle.

Function
REQ-016 FSM states: CLEAR, READY; reset enters CLEAR with clear counter = 0.
REQ-017 CLEAR: write 0 to word[counter] each cycle, counter +1; after word DEPTH-1 written, go to READY next cycle (exactly DEPTH cycles in CLEAR).
REQ-018 busy = 1 iff state is CLEAR; MemRead/MemWrite in CLEAR are dropped, no readValid, no addrErr.
REQ-019 READY write: if MemWrite and writeAddress < DEPTH, each byte with byteEn[i]=1 updated at the edge; bytes with byteEn[i]=0 unchanged.
REQ-020 READY read: if MemRead and readAddress < DEPTH, readData = word at next edge, readValid = 1 for that one cycle (latency 1).
REQ-021 Read with MemRead=0: readData holds last value, readValid = 0.
REQ-022 Same-cycle read and write to same address: readData returns the merged post-write word (write-first, per byte).
REQ-023 Same-cycle read and write to different addresses: both complete independently.
REQ-024 Out-of-range write (address >= DEPTH): memory unchanged, addrErr = 1 next cycle.
REQ-025 Out-of-range read: readData = 0, readValid = 1, addrErr = 1 next cycle.
REQ-026 byteEn = 0 with MemWrite = 1: no-op, no error unless address out of range.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 reset at any cycle (including mid-CLEAR or mid-access): next state CLEAR, counter 0, readData = 0, readValid = 0, addrErr = 0, busy = 1.
REQ-029 Access asserted in the same cycle as reset SHALL NOT modify memory.
REQ-030 Memory contents are zero only after CLEAR completes; no other initialisation relied upon.

Structure
REQ-031 Package dmem_pkg holds state enum (CLEAR, READY) and default values for DATA_W, ADDR_W, DEPTH.
REQ-032 One sub-module, dmem_byte_merge: combinational merge of old word, new data, byteEn; used by write path and REQ-022 forwarding.
REQ-033 Storage one array of DEPTH x DATA_W, single write port, clear and user writes muxed.

Verification
REQ-034 Reset, hold idle: busy = 1 for 512 cycles, then 0; read addr 0x1FF -> readData 0x00000000, readValid 1.
REQ-035 Write 0xDEADBEEF @0x010 byteEn 0xF, then byteEn 0x2 data 0x0000AA00 -> read 0x010 returns 0xDEADAAEF one cycle later.
REQ-036 Same cycle write 0x12345678 @0x020 byteEn 0xF and read 0x020 -> readData 0x12345678 next cycle.
REQ-037 DEPTH=300: write @0x12C, read @0x12C -> addrErr pulses each, readData 0, memory unchanged.
REQ-038 Reset asserted at CLEAR count 100 -> busy stays 1 another full 512 cycles; earlier write data gone.
REQ-039 Write 0xCAFEF00D @0x005 during CLEAR -> ignored; read after READY returns 0x00000000.
